cdb_broadcaster: RTL and testbench
==================================

Name: cdb_broadcaster

Overview:
- Transmit end of the common data bus (CDB). Collects completed results from the functional units and broadcasts one result per cycle on `cdb_o`.
- Every reservation station and the register-status logic snoop `cdb_o`.
- Contains a small per-FU result buffer plus a round-robin arbiter, so that simultaneous completions are serialized without loss.

Parameters:
- NUM_FU, 3: number of functional-unit result ports.
- BUF_DEPTH, 2: entries per FU result buffer. Must be at least 1.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- fu_valid_i  input  [NUM_FU]  FU i presents a completed result this cycle.
- fu_tag_i  input  rs_tag_t [NUM_FU]  tag of the reservation station owning the result.
- fu_val_i  input  word32_t [NUM_FU]  result value.
- fu_ready_o  output  [NUM_FU]  buffer i can accept a result this cycle.
- cdb_o  output  cdb_t  broadcast {tag, val}. tag == NO_VAL means idle.

Behaviour:
- Reset (clk_i edge with reset_i=1):
  - All buffers emptied; round-robin pointer = 0.
  - cdb_o.tag = NO_VAL; cdb_o.val = '0.
  - fu_ready_o = '0 while reset_i is high, otherwise derived from buffer counts.
- Reset mid-operation: all buffered, unbroadcast results are discarded. Upstream recovery is the issue logic's responsibility.
- Accept handshake:
  - Entry pushed into buffer i at the edge where fu_valid_i[i] && fu_ready_o[i].
  - fu_ready_o[i] = (count_i < BUF_DEPTH). It does not account for a same-cycle pop, so a full buffer never accepts even while draining.
  - fu_valid_i with fu_ready_o low: the result is not taken. The FU must hold it.
  - fu_valid_i with fu_tag_i == NO_VAL: ignored, never enqueued, never broadcast.
- Arbitration (combinational, every cycle):
  - Candidates are the non-empty buffers.
  - Search order starts at pointer p and continues (p+1)..(NUM_FU-1), 0..(p-1). First non-empty buffer wins.
  - At the edge, the winner's head is popped, cdb_o <= head, and p <= (winner+1) mod NUM_FU.
  - No winner: cdb_o.tag <= NO_VAL, cdb_o.val holds its previous value, p unchanged.
- Latency: a result presented and accepted in cycle c can appear on cdb_o no earlier than cycle c+2 (buffer write at end of c, arbitration in c+1, registered output in c+2).
- Each accepted result is broadcast for exactly one cycle and exactly once. No bubble is inserted between back-to-back broadcasts.
- Same-buffer push and pop at one edge: count unchanged and FIFO order preserved. An entry pushed at edge N is never popped at edge N.
- Buffer pointers wrap modulo BUF_DEPTH. The count is held in $clog2(BUF_DEPTH+1) bits.
- No ordering guarantee across FUs beyond round-robin; per-FU order is FIFO.
- cdb_o is fully registered, with no combinational path from inputs.

Decomposition:
- rs_tag_t (including NO_VAL), word32_t and cdb_t {tag, val} stay in data_types. No new package types are required.
- Add `fu_result_t {tag, val}` to data_types for buffer storage.
- Sub-module `cdb_result_fifo`: parameterized by BUF_DEPTH, stores fu_result_t, with push/pop/full/empty/head. Instantiated NUM_FU times.
- The round-robin arbiter and output register live in cdb_broadcaster.

Test Plan:
1. Single result:
   - Stimulus: after reset, fu_valid_i[0]=1 with {ALU_1, 50} in cycle c.
   - Response: cdb_o={ALU_1, 50} in cycle c+2 only; NO_VAL in c+1 and c+3.
2. Simultaneous completion:
   - Stimulus: in cycle c, FU0 {ALU_1, 10}, FU1 {ALU_2, 20}, FU2 {ALU_3, 30}.
   - Response: cdb_o = ALU_1/10, ALU_2/20, ALU_3/30 in cycles c+2, c+3, c+4; NO_VAL in c+5.
3. Fairness:
   - Stimulus: FU0 and FU1 both push every cycle for 6 cycles (FU0 values 1..6, FU1 values 101..106).
   - Response: broadcasts alternate strictly between ALU_1 and ALU_2. Per-FU values appear in push order.
4. Backpressure:
   - Stimulus: all three FUs hold fu_valid_i=1 for 8 cycles.
   - Response: fu_ready_o[i] drops when its buffer reaches 2 entries. Every accepted handshake is broadcast exactly once; the broadcast count equals the accepted count.
5. Reset mid-operation:
   - Stimulus: buffer 2 entries (ALU_1/7, ALU_2/8), then assert reset_i for one cycle before the first broadcast.
   - Response: cdb_o.tag = NO_VAL from the reset edge onward; neither 7 nor 8 is ever broadcast.
6. NO_VAL input:
   - Stimulus: fu_valid_i[1]=1 with {NO_VAL, 99}.
   - Response: cdb_o stays NO_VAL and buffer 1 stays empty (fu_ready_o[1]=1).

Source files
------------

// File: rtl/cdb_broadcaster_pkg.sv
// Shared types for the common data bus: reservation-station tags, data words,
// the broadcast record and the per-FU buffered result.
package cdb_broadcaster_pkg;

   typedef logic [31:0] word32_t;

   typedef enum logic [2:0] {
      NO_VAL = 3'd0,
      ALU_1  = 3'd1,
      ALU_2  = 3'd2,
      ALU_3  = 3'd3,
      MUL_1  = 3'd4,
      MUL_2  = 3'd5,
      LOAD_1 = 3'd6,
      LOAD_2 = 3'd7
   } rs_tag_t;

   typedef struct packed {
      rs_tag_t tag;
      word32_t val;
   } cdb_t;

   typedef struct packed {
      rs_tag_t tag;
      word32_t val;
   } fu_result_t;

   // NO_VAL marks "nothing here", so it is never a result worth keeping.
   function automatic logic isRealTag(input rs_tag_t tag);
      return tag != NO_VAL;
   endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Small FIFO holding completed results of one functional unit until the
// CDB arbiter grants it a broadcast slot.
module cdb_result_fifo
   import cdb_broadcaster_pkg::*;
#(
   parameter int BUF_DEPTH = 2
)
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       push_i,
   input  fu_result_t data_i,
   input  logic       pop_i,
   output logic       full_o,
   output logic       empty_o,
   output fu_result_t head_o
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   fu_result_t       r_mem [BUF_DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign full_o  = (r_count == CNT_W'(BUF_DEPTH));
   assign empty_o = (r_count == '0);
   assign head_o  = r_mem[r_rdPtr];

   always_ff @(posedge clk_i) begin
      if (push_i)
         r_mem[r_wrPtr] <= data_i;
   end

   // A simultaneous push and pop leaves the count alone; the pop always
   // takes the old head, so a freshly pushed entry cannot leave in the same edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (push_i)
            r_wrPtr <= nextPtr(r_wrPtr);
         if (pop_i)
            r_rdPtr <= nextPtr(r_rdPtr);
         case ({push_i, pop_i})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/cdb_broadcaster.sv
// Transmit end of the common data bus: buffers FU results and broadcasts one
// per cycle, choosing among non-empty buffers in round-robin order.
module cdb_broadcaster
   import cdb_broadcaster_pkg::*;
#(
   parameter int NUM_FU    = 3,
   parameter int BUF_DEPTH = 2
)
(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [NUM_FU-1:0] fu_valid_i,
   input  rs_tag_t           fu_tag_i [NUM_FU],
   input  word32_t           fu_val_i [NUM_FU],
   output logic [NUM_FU-1:0] fu_ready_o,
   output cdb_t              cdb_o
);

   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0] w_full;
   logic [NUM_FU-1:0] w_empty;
   logic [NUM_FU-1:0] w_push;
   logic [NUM_FU-1:0] w_pop;
   fu_result_t        w_head [NUM_FU];
   logic              w_found;
   logic [PTR_W-1:0]  w_winner;
   logic [PTR_W-1:0]  w_cand;
   int                w_idx;
   logic [PTR_W-1:0]  r_ptr;
   cdb_t              r_cdb;

   for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
      fu_result_t w_pushData;

      // Readiness ignores a same-cycle pop, so a full buffer never accepts.
      assign fu_ready_o[g] = !reset_i && !w_full[g];
      assign w_push[g]     = fu_valid_i[g] && fu_ready_o[g] && isRealTag(fu_tag_i[g]);
      assign w_pop[g]      = w_found && (w_winner == PTR_W'(g));
      assign w_pushData    = '{tag: fu_tag_i[g], val: fu_val_i[g]};

      cdb_result_fifo #(
         .BUF_DEPTH(BUF_DEPTH)
      ) u_fifo (
         .clk_i  (clk_i),
         .reset_i(reset_i),
         .push_i (w_push[g]),
         .data_i (w_pushData),
         .pop_i  (w_pop[g]),
         .full_o (w_full[g]),
         .empty_o(w_empty[g]),
         .head_o (w_head[g])
      );
   end

   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_cand   = '0;
      w_idx    = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= NUM_FU)
            w_idx = w_idx - NUM_FU;
         w_cand = PTR_W'(w_idx);
         if (!w_found && !w_empty[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   // With no winner only the tag goes idle; the value keeps its last contents.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_ptr <= '0;
         r_cdb <= '{tag: NO_VAL, val: '0};
      end else if (w_found) begin
         r_cdb <= '{tag: w_head[w_winner].tag, val: w_head[w_winner].val};
         r_ptr <= (w_winner == PTR_W'(NUM_FU - 1)) ? '0 : w_winner + 1'b1;
      end else begin
         r_cdb.tag <= NO_VAL;
      end
   end

   assign cdb_o = r_cdb;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Testbench for cdb_broadcaster: queue-based reference model with a per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
module tb_cdb_broadcaster;
   import cdb_broadcaster_pkg::*;

   localparam int NUM_FU    = 3;
   localparam int BUF_DEPTH = 2;

   logic              clk   = 1'b0;
   logic              reset = 1'b1;
   logic [NUM_FU-1:0] fuValid = '0;
   rs_tag_t           fuTag [NUM_FU];
   word32_t           fuVal [NUM_FU];
   logic [NUM_FU-1:0] fuReady;
   cdb_t              cdb;

   int                checkCount = 0;
   int                errorCount = 0;
   logic [NUM_FU-1:0] lastReady = '0;

   fu_result_t        modelQ [NUM_FU][$];
   int                modelPtr = 0;
   rs_tag_t           expTag = NO_VAL;
   word32_t           expVal = '0;
   int                modelAccepted = 0;
   fu_result_t        dutLog [$];
   int                dutBcast = 0;

   always #5 clk = ~clk;

   cdb_broadcaster #(
      .NUM_FU   (NUM_FU),
      .BUF_DEPTH(BUF_DEPTH)
   ) dut (
      .clk_i     (clk),
      .reset_i   (reset),
      .fu_valid_i(fuValid),
      .fu_tag_i  (fuTag),
      .fu_val_i  (fuVal),
      .fu_ready_o(fuReady),
      .cdb_o     (cdb)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Reference model: one FIFO queue per FU, a round-robin start index, and the
   // value the bus must show after each edge.
   always @(posedge clk) begin
      bit         found;
      int         win;
      bit         acc [NUM_FU];
      fu_result_t item;
      if (reset) begin
         for (int i = 0; i < NUM_FU; i++)
            modelQ[i].delete();
         modelPtr = 0;
         expTag   = NO_VAL;
         expVal   = '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++)
            acc[i] = fuValid[i] && (modelQ[i].size() < BUF_DEPTH) && (fuTag[i] != NO_VAL);
         found = 0;
         win   = 0;
         for (int k = 0; k < NUM_FU; k++) begin
            if (!found && modelQ[(modelPtr + k) % NUM_FU].size() != 0) begin
               found = 1;
               win   = (modelPtr + k) % NUM_FU;
            end
         end
         if (found) begin
            item     = modelQ[win].pop_front();
            expTag   = item.tag;
            expVal   = item.val;
            modelPtr = (win + 1) % NUM_FU;
         end else begin
            expTag = NO_VAL;
         end
         for (int i = 0; i < NUM_FU; i++) begin
            if (acc[i]) begin
               modelQ[i].push_back('{tag: fuTag[i], val: fuVal[i]});
               modelAccepted++;
            end
         end
      end
   end

   // Per-cycle compare of every output against the model, shortly after the edge.
   always @(posedge clk) begin
      #1;
      checkOutput("cdb_tag", 32'(cdb.tag), 32'(expTag));
      checkOutput("cdb_val", cdb.val, expVal);
      for (int i = 0; i < NUM_FU; i++)
         checkOutput($sformatf("fu_ready[%0d]", i), 32'(fuReady[i]),
                     32'(!reset && (modelQ[i].size() < BUF_DEPTH)));
      if (cdb.tag != NO_VAL) begin
         dutLog.push_back('{tag: cdb.tag, val: cdb.val});
         dutBcast++;
      end
   end

   // Drive reset for the next edge, capture the pre-edge ready, then wait past the edge.
   task automatic applyStimulus(input logic rst);
      @(negedge clk);
      reset = rst;
      #1;
      lastReady = fuReady;
      @(posedge clk);
      #2;
   endtask

   task automatic setFu(input int i, input logic v, input rs_tag_t t, input word32_t val);
      fuValid[i] = v;
      fuTag[i]   = t;
      fuVal[i]   = val;
   endtask

   task automatic idleAll();
      for (int i = 0; i < NUM_FU; i++)
         setFu(i, 1'b0, NO_VAL, '0);
   endtask

   task automatic doReset();
      idleAll();
      applyStimulus(1'b1);
   endtask

   task automatic expectCdb(input string name, input rs_tag_t t, input word32_t v);
      checkOutput({name, "_tag"}, 32'(cdb.tag), 32'(t));
      if (t != NO_VAL)
         checkOutput({name, "_val"}, cdb.val, v);
   endtask

   initial begin
      int  sent [NUM_FU];
      int  hsCount;
      bit  pending [NUM_FU];
      int  cyc;

      idleAll();
      doReset();
      doReset();
      expectCdb("reset", NO_VAL, '0);
      checkOutput("reset_val", cdb.val, 32'd0);
      checkOutput("reset_ready", 32'(fuReady), 32'd0);

      // Single result: visible exactly two cycles after presentation.
      setFu(0, 1'b1, ALU_1, 32'd50);
      applyStimulus(1'b0);
      expectCdb("t1_c1", NO_VAL, '0);
      checkOutput("t1_ready", 32'(fuReady), 32'b111);
      idleAll();
      applyStimulus(1'b0);
      expectCdb("t1_c2", ALU_1, 32'd50);
      applyStimulus(1'b0);
      expectCdb("t1_c3", NO_VAL, '0);

      // Simultaneous completion on all three FUs.
      doReset();
      setFu(0, 1'b1, ALU_1, 32'd10);
      setFu(1, 1'b1, ALU_2, 32'd20);
      setFu(2, 1'b1, ALU_3, 32'd30);
      applyStimulus(1'b0);
      expectCdb("t2_c1", NO_VAL, '0);
      idleAll();
      applyStimulus(1'b0);
      expectCdb("t2_c2", ALU_1, 32'd10);
      applyStimulus(1'b0);
      expectCdb("t2_c3", ALU_2, 32'd20);
      applyStimulus(1'b0);
      expectCdb("t2_c4", ALU_3, 32'd30);
      applyStimulus(1'b0);
      expectCdb("t2_c5", NO_VAL, '0);

      // Reset before the first broadcast discards buffered results.
      doReset();
      setFu(0, 1'b1, ALU_1, 32'd7);
      setFu(1, 1'b1, ALU_2, 32'd8);
      applyStimulus(1'b0);
      idleAll();
      applyStimulus(1'b1);
      expectCdb("t5_reset", NO_VAL, '0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0);
         expectCdb("t5_after", NO_VAL, '0);
      end
      checkOutput("t5_ready", 32'(fuReady), 32'b111);

      // A NO_VAL tag is never buffered.
      doReset();
      setFu(1, 1'b1, NO_VAL, 32'd99);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0);
         expectCdb("t6_idle", NO_VAL, '0);
         checkOutput("t6_ready1", 32'(fuReady[1]), 32'd1);
      end

      // Fairness: two FUs streaming with a held-until-accepted handshake.
      doReset();
      dutLog.delete();
      sent[0] = 0;
      sent[1] = 0;
      cyc = 0;
      while ((sent[0] < 6 || sent[1] < 6) && cyc < 40) begin
         setFu(0, sent[0] < 6, ALU_1, 32'(sent[0] + 1));
         setFu(1, sent[1] < 6, ALU_2, 32'(sent[1] + 101));
         applyStimulus(1'b0);
         for (int i = 0; i < 2; i++)
            if (fuValid[i] && lastReady[i])
               sent[i]++;
         cyc++;
      end
      checkOutput("t3_sent", 32'(sent[0] + sent[1]), 32'd12);
      idleAll();
      for (int k = 0; k < 6; k++)
         applyStimulus(1'b0);
      checkOutput("t3_count", 32'(dutLog.size()), 32'd12);
      for (int k = 0; k < 12 && k < dutLog.size(); k++) begin
         checkOutput("t3_tag", 32'(dutLog[k].tag), (k % 2 == 0) ? 32'(ALU_1) : 32'(ALU_2));
         checkOutput("t3_val", dutLog[k].val, (k % 2 == 0) ? 32'(k / 2 + 1) : 32'(k / 2 + 101));
      end

      // Backpressure: all FUs keep offering for 8 cycles.
      doReset();
      modelAccepted = 0;
      dutBcast = 0;
      hsCount = 0;
      for (int i = 0; i < NUM_FU; i++)
         sent[i] = 0;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NUM_FU; i++)
            setFu(i, 1'b1, rs_tag_t'(3'(i + 1)), 32'(1000 * i + sent[i]));
         applyStimulus(1'b0);
         for (int i = 0; i < NUM_FU; i++)
            if (lastReady[i]) begin
               sent[i]++;
               hsCount++;
            end
      end
      idleAll();
      for (int k = 0; k < 10; k++)
         applyStimulus(1'b0);
      checkOutput("t4_handshakes", 32'(hsCount), 32'd12);
      checkOutput("t4_model_acc", 32'(modelAccepted), 32'd12);
      checkOutput("t4_bcast", 32'(dutBcast), 32'(modelAccepted));

      // Random traffic with occasional resets; the compare process does the checking.
      for (int i = 0; i < NUM_FU; i++)
         pending[i] = 0;
      for (int k = 0; k < 500; k++) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
               setFu(i, 1'b1, rs_tag_t'(3'($urandom_range(0, 7))), $urandom);
               pending[i] = 1;
            end else if (!pending[i]) begin
               fuValid[i] = 1'b0;
            end
         end
         applyStimulus($urandom_range(0, 63) == 0);
         for (int i = 0; i < NUM_FU; i++)
            if (pending[i] && lastReady[i])
               pending[i] = 0;
      end
      idleAll();
      for (int k = 0; k < 10; k++)
         applyStimulus(1'b0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
